multi_byte_alu_seq: RTL and testbench
=====================================

// Module: multi_byte_alu_seq
// PURPOSE
//  Multi-precision add/subtract sequencer for the SAP-2 datapath. It consumes two
//  operand byte streams, least-significant byte first, and emits one result byte
//  per operand pair, propagating carry/borrow between bytes.
//  Generalises the single-byte ADC/SBC path to N-byte operations with
//  ready/valid handshakes, a compare-only mode, and whole-word Z/N/C/V flags.
// PARAMETERS
//  DATA_WIDTH  8  width of one operand/result byte
//  MAX_BYTES   4  maximum bytes per operation
//  LEN_W       $clog2(MAX_BYTES+1)  width of num_bytes
// PORTS
//  clk            in   1           system clock, rising edge
//  reset          in   1           asynchronous, active-low reset
//  start          in   1           begin operation (sampled only while busy=0)
//  op             in   3           alu_seq_op_t
//  num_bytes      in   LEN_W       byte count; 1..MAX_BYTES
//  carry_in       in   1           CPU C flag, used by ADC/SBC
//  in_valid       in   1           in_a/in_b hold a valid byte pair
//  in_a, in_b     in   DATA_WIDTH  operand bytes, LSB first
//  in_ready       out  1           sequencer accepts a pair this cycle
//  out_valid      out  1           out_data holds a valid result byte
//  out_data       out  DATA_WIDTH  result byte, LSB first
//  out_ready      in   1           consumer accepts out_data
//  busy           out  1           operation in progress
//  done           out  1           one-cycle pulse on completion
//  flag_carry_o, flag_zero_o, flag_negative_o, flag_overflow_o  out 1 each
// BEHAVIOUR
//  - Reset (async, active-low): all outputs 0, FSM=IDLE, byte counter=0, carry reg=0.
//  - Carry convention: C=1 means no borrow on subtract.
//    SUB/SBC/CMP compute a + ~b + c.
//  - First-byte carry: ADD=0, SUB=1, CMP=1, ADC/SBC=carry_in (sampled at start).
//  - FSM states:
//    - IDLE: on start with num_bytes!=0, latch op, len, and carry; go to RUN; busy=1.
//      On start with num_bytes==0: done pulses next cycle, flags unchanged, stay IDLE.
//    - RUN: in_ready = !out_valid || out_ready. On in_valid&&in_ready, compute a byte,
//      register out_data/out_valid (latency 1 cycle), update carry, AND-accumulate zero,
//      increment the counter. The last pair goes to DRAIN.
//      CMP never asserts out_valid; its last pair goes to FIN.
//    - DRAIN: wait for out_valid&&out_ready on the last byte, then go to FIN.
//    - FIN: update flags, pulse done, busy=0, return to IDLE.
//  - Flags are written only in FIN and hold until the next completed operation:
//    - C: final carry out.
//    - Z: 1 iff every result byte == 0.
//    - N: MSB of the last byte.
//    - V: signed overflow of the last byte.
//  - out_valid holds with stable out_data until out_ready is seen. No byte is dropped
//    or duplicated under any backpressure pattern.
//  - start while busy=1 is ignored. num_bytes > MAX_BYTES is clamped to MAX_BYTES.
//  - Reset mid-operation aborts immediately, with no done pulse. Partial results are discarded.
//  - Counter wraps only via return to IDLE; the carry register never leaks across operations.
// STRUCTURE
//  - arch_defs_pkg: typedef enum logic [2:0] alu_seq_op_t
//    {OP_ADD=0, OP_ADC=1, OP_SUB=2, OP_SBC=3, OP_CMP=4}; typedef for FSM state.
//  - Sub-module alu_byte_slice: combinational; (a, b, cin, sub) -> (sum, cout, ovf).
//    It is instantiated once. The sequencer holds the FSM, counter, carry/zero
//    accumulators, and output register.
// TESTING
//  1. SBC, len 1, carry_in=1, A=00, B=01 -> out FF; C=0, Z=0, N=1, V=0; done 1 pulse.
//  2. SBC, len 1, carry_in=0, A=FF, B=FE -> out 00; C=1, Z=1, N=0.
//  3. SUB, len 2, 0x0100-0x0001 -> bytes FF,00; C=1, Z=0, N=0, V=0.
//  4. ADD, len 4, FFFFFFFF+00000001 -> 00,00,00,00; C=1, Z=1, N=0.
//  5. CMP, len 1, 80 vs 01 -> out_valid never high; C=1, Z=0, N=0, V=1; A unchanged.
//  6. ADD, len 2, with out_ready low 3 cycles after byte 0 -> in_ready low meanwhile;
//     bytes exact and ordered.
//  7. Reset low mid-RUN of a len-4 op -> all outputs 0 at once, no done;
//     the next op (test 3) passes.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: shared op/state types and carry helpers for the multi-byte ALU sequencer
//   alu_seq_op_t  : ADD/ADC/SUB/SBC/CMP operation codes
//   seq_state_t   : sequencer FSM states
//   is_sub        : op computes a + ~b + c
//   first_carry   : carry fed into the least-significant byte
package arch_defs_pkg;
   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_ADC = 3'd1,
      OP_SUB = 3'd2,
      OP_SBC = 3'd3,
      OP_CMP = 3'd4
   } alu_seq_op_t;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } seq_state_t;
   function automatic logic is_sub(alu_seq_op_t op);
      return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
   endfunction
   // C=1 means "no borrow", so plain SUB/CMP start with carry set.
   function automatic logic first_carry(alu_seq_op_t op, logic cin);
      return (op == OP_ADD) ? 1'b0 : ((op == OP_ADC) || (op == OP_SBC)) ? cin : 1'b1;
   endfunction
endpackage

// File: rtl/alu_byte_slice.sv
// alu_byte_slice: one byte of add/subtract-with-carry
//   a, b  : operand bytes
//   cin   : incoming carry (1 = no borrow when subtracting)
//   sub   : 1 selects a + ~b + cin
//   sum   : result byte
//   cout  : carry out of the byte
//   ovf   : signed overflow of this byte
module alu_byte_slice #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  cin,
   input  logic                  sub,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  cout,
   output logic                  ovf
);
   logic [DATA_WIDTH-1:0] bx;
   always_comb begin
      bx = sub ? ~b : b;
      {cout, sum} = {1'b0, a} + {1'b0, bx} + {{DATA_WIDTH{1'b0}}, cin};
      ovf = (a[DATA_WIDTH-1] == bx[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
   end
endmodule

// File: rtl/multi_byte_alu_seq.sv
// multi_byte_alu_seq: LSB-first multi-byte add/subtract/compare sequencer with ready/valid streams
//   clk, reset (async, active-low)
//   start/op/num_bytes/carry_in : operation request, sampled while idle
//   in_valid/in_ready/in_a/in_b : operand byte stream, LSB first
//   out_valid/out_ready/out_data: result byte stream, LSB first (silent for CMP)
//   busy, done                  : operation in progress / one-cycle completion pulse
//   flag_*_o                    : whole-word C/Z/N/V, updated on completion only
module multi_byte_alu_seq
   import arch_defs_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BYTES  = 4,
   parameter int LEN_W      = $clog2(MAX_BYTES + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  alu_seq_op_t           op,
   input  logic [LEN_W-1:0]      num_bytes,
   input  logic                  carry_in,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  flag_carry_o,
   output logic                  flag_zero_o,
   output logic                  flag_negative_o,
   output logic                  flag_overflow_o
);
   seq_state_t            state;
   alu_seq_op_t           op_r;
   logic [LEN_W-1:0]      len_r;
   logic [LEN_W-1:0]      cnt;
   logic [LEN_W-1:0]      len_clamp;
   logic                  carry_r;
   logic                  zero_r;
   logic                  neg_r;
   logic                  ovf_r;
   logic [DATA_WIDTH-1:0] sum;
   logic                  cout;
   logic                  ovf;
   logic                  last;
   alu_byte_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
      .a    (in_a),
      .b    (in_b),
      .cin  (carry_r),
      .sub  (is_sub(op_r)),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf)
   );
   // A new pair may enter whenever the output register is empty or being emptied.
   assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
   assign len_clamp = (num_bytes > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : num_bytes;
   assign last      = (cnt == len_r - LEN_W'(1));
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         op_r            <= OP_ADD;
         len_r           <= '0;
         cnt             <= '0;
         carry_r         <= 1'b0;
         zero_r          <= 1'b0;
         neg_r           <= 1'b0;
         ovf_r           <= 1'b0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         flag_carry_o    <= 1'b0;
         flag_zero_o     <= 1'b0;
         flag_negative_o <= 1'b0;
         flag_overflow_o <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && num_bytes == '0) done <= 1'b1;
               else if (start) begin
                  op_r    <= op;
                  len_r   <= len_clamp;
                  cnt     <= '0;
                  carry_r <= first_carry(op, carry_in);
                  zero_r  <= 1'b1;
                  busy    <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               if (out_valid && out_ready) out_valid <= 1'b0;
               if (in_valid && in_ready) begin
                  if (op_r != OP_CMP) begin
                     out_data  <= sum;
                     out_valid <= 1'b1;
                  end
                  carry_r <= cout;
                  zero_r  <= zero_r && (sum == '0);
                  neg_r   <= sum[DATA_WIDTH-1];
                  ovf_r   <= ovf;
                  cnt     <= cnt + LEN_W'(1);
                  if (last) state <= (op_r == OP_CMP) ? S_FIN : S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_FIN;
               end
            end
            S_FIN: begin
               flag_carry_o    <= carry_r;
               flag_zero_o     <= zero_r;
               flag_negative_o <= neg_r;
               flag_overflow_o <= ovf_r;
               done            <= 1'b1;
               busy            <= 1'b0;
               cnt             <= '0;
               carry_r         <= 1'b0;
               state           <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multi_byte_alu_seq.sv
// tb_multi_byte_alu_seq: randomized and directed self-checking bench for multi_byte_alu_seq
module tb_multi_byte_alu_seq;
   import arch_defs_pkg::*;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   alu_seq_op_t op = OP_ADD;
   logic [2:0]  num_bytes = '0;
   logic        carry_in = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        done;
   logic        fc, fz, fn, fv;
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  got[$];
   int          dones, hold_viol, ready_viol, stall_cyc;
   bit          ov_seen, busy_seen, timed_out;

   multi_byte_alu_seq dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .op              (op),
      .num_bytes       (num_bytes),
      .carry_in        (carry_in),
      .in_valid        (in_valid),
      .in_a            (in_a),
      .in_b            (in_b),
      .in_ready        (in_ready),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_ready       (out_ready),
      .busy            (busy),
      .done            (done),
      .flag_carry_o    (fc),
      .flag_zero_o     (fz),
      .flag_negative_o (fn),
      .flag_overflow_o (fv)
   );

   always #5 clk = ~clk;

   // Whole-word arithmetic reference: result and {C,Z,N,V}.
   function automatic void model(input alu_seq_op_t o, input int n, input bit cin,
                                 input longint a, input longint b,
                                 output longint res, output logic [3:0] fl);
      longint mask, aa, bx, t;
      bit s, c0, sa, sb, sr;
      mask = (longint'(1) << (8 * n)) - 1;
      s  = (o == OP_SUB) || (o == OP_SBC) || (o == OP_CMP);
      c0 = (o == OP_ADD) ? 1'b0 : ((o == OP_ADC) || (o == OP_SBC)) ? cin : 1'b1;
      aa = a & mask;
      bx = s ? (~b & mask) : (b & mask);
      t  = aa + bx + longint'(c0);
      res = t & mask;
      sa = aa[8*n-1];
      sb = bx[8*n-1];
      sr = res[8*n-1];
      fl = {t[8*n], res == 0, sr, (sa == sb) && (sr != sa)};
   endfunction

   function automatic longint got_val();
      longint v = 0;
      for (int i = 0; i < got.size(); i++) v = v | (longint'(got[i]) << (8 * i));
      return v;
   endfunction

   // Drives one operation and records what the DUT streamed back.
   task automatic run_op(input alu_seq_op_t o, input int nb, input bit cin, input longint a,
                         input longint b, input int bp, input int stall, input bit poke);
      int n, idx, cyc, stall_left;
      bit first_seen, prev_stall, acc;
      logic [7:0] prev_data;
      n = (nb > 4) ? 4 : nb;
      idx = 0; cyc = 0; stall_left = 0; first_seen = 0; prev_stall = 0; prev_data = '0;
      got.delete();
      dones = 0; hold_viol = 0; ready_viol = 0; stall_cyc = 0; ov_seen = 0; timed_out = 0;
      @(negedge clk);
      op = o; num_bytes = 3'(nb); carry_in = cin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_seen = busy;
      if (done) dones++;
      while (n > 0 && dones == 0 && cyc < 300) begin
         if (prev_stall && (!out_valid || out_data !== prev_data)) hold_viol++;
         if (out_valid && !first_seen) begin
            first_seen = 1;
            stall_left = stall;
         end
         out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) >= bp);
         if (stall_left > 0) stall_left--;
         in_valid = (idx < n) && (bp == 0 || $urandom_range(3) != 0);
         in_a = (idx < n) ? 8'(a >> (8 * idx)) : 8'h00;
         in_b = (idx < n) ? 8'(b >> (8 * idx)) : 8'h00;
         start = poke && cyc == 1;
         if (start) begin
            op = OP_CMP;
            num_bytes = 3'd1;
         end
         #1;
         if (out_valid && !out_ready && in_ready) ready_viol++;
         if (out_valid && !out_ready) stall_cyc++;
         if (out_valid) ov_seen = 1;
         if (out_valid && out_ready) got.push_back(out_data);
         acc = in_valid && in_ready;
         prev_stall = out_valid && !out_ready;
         prev_data = out_data;
         @(negedge clk);
         start = 1'b0;
         if (acc) idx++;
         if (done) dones++;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      if (n > 0) begin
         checks++;
         if (dones == 0) begin
            timed_out = 1;
            failures++;
            $display("FAIL timeout op=%0d len=%0d got=no_done exp=done", o, nb);
         end
      end
      @(negedge clk);
      if (done) dones++;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_data, busy, done, fc, fz, fn, fv} !== 16'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {in_ready, out_valid, out_data, busy, done, fc, fz, fn, fv});
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, busy, done} !== 3'b000) begin
         failures++;
         $display("FAIL idle_after_reset got=%b exp=000", {in_ready, busy, done});
      end
   endtask

   task automatic test_directed;
      alu_seq_op_t d_op[5]  = '{OP_SBC, OP_SBC, OP_SUB, OP_ADD, OP_CMP};
      int          d_n[5]   = '{1, 1, 2, 4, 1};
      bit          d_c[5]   = '{1, 0, 0, 0, 0};
      longint      d_a[5]   = '{64'h00, 64'hFF, 64'h0100, 64'hFFFF_FFFF, 64'h80};
      longint      d_b[5]   = '{64'h01, 64'hFE, 64'h0001, 64'h1, 64'h01};
      longint      d_res[5] = '{64'hFF, 64'h00, 64'h00FF, 64'h0, 64'h0};
      logic [3:0]  d_fl[5]  = '{4'b0010, 4'b1100, 4'b1000, 4'b1100, 4'b1001};
      int          d_cnt[5] = '{1, 1, 2, 4, 0};
      for (int i = 0; i < 5; i++) begin
         run_op(d_op[i], d_n[i], d_c[i], d_a[i], d_b[i], 0, 0, 0);
         checks++;
         if (got.size() != d_cnt[i] || got_val() !== d_res[i]) begin
            failures++;
            $display("FAIL directed%0d_result got=%0d bytes %h exp=%0d bytes %h", i, got.size(), got_val(), d_cnt[i], d_res[i]);
         end
         checks++;
         if ({fc, fz, fn, fv} !== d_fl[i]) begin
            failures++;
            $display("FAIL directed%0d_flags got=%b exp=%b", i, {fc, fz, fn, fv}, d_fl[i]);
         end
         checks++;
         if (dones != 1 || ov_seen != (d_cnt[i] != 0) || busy_seen !== 1'b1) begin
            failures++;
            $display("FAIL directed%0d_ctrl got=done%0d ov%0d busy%0d exp=done1 ov%0d busy1", i, dones, ov_seen, busy_seen, d_cnt[i] != 0);
         end
      end
   endtask

   task automatic test_backpressure;
      run_op(OP_ADD, 2, 0, 64'h12F0, 64'h0125, 0, 3, 0);
      checks++;
      if (got.size() != 2 || got_val() !== 64'h1415) begin
         failures++;
         $display("FAIL bp_bytes got=%0d bytes %h exp=2 bytes 1415", got.size(), got_val());
      end
      checks++;
      if (stall_cyc != 3 || ready_viol != 0 || hold_viol != 0) begin
         failures++;
         $display("FAIL bp_stall got=stall%0d rdy%0d hold%0d exp=stall3 rdy0 hold0", stall_cyc, ready_viol, hold_viol);
      end
      checks++;
      if ({fc, fz, fn, fv} !== 4'b0000 || dones != 1) begin
         failures++;
         $display("FAIL bp_flags got=%b done%0d exp=0000 done1", {fc, fz, fn, fv}, dones);
      end
   endtask

   task automatic test_zero_len;
      longint res;
      logic [3:0] fl;
      model(OP_SUB, 1, 0, 64'h10, 64'h20, res, fl);
      run_op(OP_SUB, 1, 0, 64'h10, 64'h20, 0, 0, 0);
      run_op(OP_ADD, 0, 0, 64'h0, 64'h0, 0, 0, 0);
      checks++;
      if (dones != 1 || busy_seen !== 1'b0 || got.size() != 0) begin
         failures++;
         $display("FAIL zero_len_ctrl got=done%0d busy%0d bytes%0d exp=done1 busy0 bytes0", dones, busy_seen, got.size());
      end
      checks++;
      if ({fc, fz, fn, fv} !== fl) begin
         failures++;
         $display("FAIL zero_len_flags got=%b exp=%b", {fc, fz, fn, fv}, fl);
      end
   endtask

   task automatic test_clamp_and_ignore;
      longint a, b, res;
      logic [3:0] fl;
      a = longint'($urandom);
      b = longint'($urandom);
      model(OP_SUB, 4, 0, a, b, res, fl);
      run_op(OP_SUB, 7, 0, a, b, 30, 0, 1);
      checks++;
      if (got.size() != 4 || got_val() !== res) begin
         failures++;
         $display("FAIL clamp_result got=%0d bytes %h exp=4 bytes %h", got.size(), got_val(), res);
      end
      checks++;
      if ({fc, fz, fn, fv} !== fl || dones != 1) begin
         failures++;
         $display("FAIL clamp_flags got=%b done%0d exp=%b done1", {fc, fz, fn, fv}, dones, fl);
      end
   endtask

   task automatic test_reset_mid;
      int dcount;
      @(negedge clk);
      op = OP_ADD; num_bytes = 3'd4; carry_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_a = 8'h11; in_b = 8'h22;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_data, busy, done, fc, fz, fn, fv} !== 16'h0) begin
         failures++;
         $display("FAIL reset_mid_outputs got=%h exp=0", {in_ready, out_valid, out_data, busy, done, fc, fz, fn, fv});
      end
      in_valid = 1'b0;
      dcount = 0;
      @(negedge clk);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      checks++;
      if (dcount != 0) begin
         failures++;
         $display("FAIL reset_mid_no_done got=%0d exp=0", dcount);
      end
      run_op(OP_SUB, 2, 0, 64'h0100, 64'h0001, 20, 0, 0);
      checks++;
      if (got.size() != 2 || got_val() !== 64'h00FF || {fc, fz, fn, fv} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_mid_next got=%0d bytes %h flags %b exp=2 bytes 00ff flags 1000", got.size(), got_val(), {fc, fz, fn, fv});
      end
   endtask

   task automatic test_random;
      alu_seq_op_t o;
      int n;
      bit cin;
      longint a, b, res;
      logic [3:0] fl;
      for (int it = 0; it < 30; it++) begin
         o = alu_seq_op_t'(3'($urandom_range(4)));
         n = $urandom_range(4, 1);
         cin = 1'($urandom_range(1));
         a = longint'($urandom);
         b = longint'($urandom);
         model(o, n, cin, a, b, res, fl);
         run_op(o, n, cin, a, b, $urandom_range(60), $urandom_range(3), 1'($urandom_range(1)));
         checks++;
         if (got.size() != ((o == OP_CMP) ? 0 : n) || (o != OP_CMP && got_val() !== res)) begin
            failures++;
            $display("FAIL rand%0d_result op=%0d len=%0d got=%0d bytes %h exp=%h", it, o, n, got.size(), got_val(), res);
         end
         checks++;
         if ({fc, fz, fn, fv} !== fl) begin
            failures++;
            $display("FAIL rand%0d_flags op=%0d len=%0d got=%b exp=%b", it, o, n, {fc, fz, fn, fv}, fl);
         end
         checks++;
         if (dones != 1 || hold_viol != 0 || ready_viol != 0) begin
            failures++;
            $display("FAIL rand%0d_handshake got=done%0d hold%0d rdy%0d exp=done1 hold0 rdy0", it, dones, hold_viol, ready_viol);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_directed;
      test_backpressure;
      test_zero_len;
      test_clamp_and_ignore;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
